spi_flash_seq: RTL and testbench

Byte-sequencer that drives the existing byte-wide SPI shift engine to run a complete SPI-flash read transaction: chip-select, command byte, optional 24-bit address, then N data bytes, with an internal receive FIFO. It sits on the A15 I/O bus beside the UART and timer and owns the engine's start/din port and a dedicated CS_b pin. The CPU no longer hand-issues every byte and polls busy.

---
 rtl/spi_flash_seq_pkg.sv | 56 +++++
 rtl/spi_flash_seq_fifo.sv | 75 +++++++
 rtl/spi_flash_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_spi_flash_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_seq_pkg.sv
// Shared constants and types for the SPI-flash read sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_seq_pkg;

  // Bus register map (STATUS read and CTRL write share address 5)
  localparam logic [2:0] REG_CMD   = 3'd0;
  localparam logic [2:0] REG_ADDR0 = 3'd1;
  localparam logic [2:0] REG_ADDR1 = 3'd2;
  localparam logic [2:0] REG_ADDR2 = 3'd3;
  localparam logic [2:0] REG_LEN   = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;
  localparam logic [2:0] REG_STAT  = 3'd5;
  localparam logic [2:0] REG_DATA  = 3'd6;
  localparam logic [2:0] REG_CNT   = 3'd7;

  // CTRL write bit positions
  localparam int CTRL_GO      = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_ADDR_EN = 2;
  localparam int CTRL_IRQ_EN  = 3;

  // Byte clocked out during the data phase and returned on an empty pop
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_CAPTURE,
    ST_DESEL
  } seq_state_e;

  // Which byte of the transaction is being shifted
  typedef enum logic [2:0] {
    PH_CMD,
    PH_ADDR2,
    PH_ADDR1,
    PH_ADDR0,
    PH_DATA
  } seq_phase_e;

  // Phase that follows a completed byte; the address is skipped when disabled
  function automatic seq_phase_e next_phase(input seq_phase_e ph, input logic addr_en);
    case (ph)
      PH_CMD:   next_phase = addr_en ? PH_ADDR2 : PH_DATA;
      PH_ADDR2: next_phase = PH_ADDR1;
      PH_ADDR1: next_phase = PH_ADDR0;
      default:  next_phase = PH_DATA;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_seq_fifo.sv
// Synchronous byte FIFO holding received flash data for the CPU.
// Latency: a push is visible at the head one cycle later; the head is read combinationally.
// Backpressure: push while full and pop while empty are dropped; an empty pop reads FILL_BYTE.
module seq_fifo
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     xclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_dat,
  input  logic                     pop,
  output logic [7:0]               pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = empty ? FILL_BYTE : mem_q[rd_ptr_q];

  // Pointer, storage and occupancy update; push+pop together leaves count alone
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: reset empties the FIFO
  always_ff @(posedge xclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; unoccupied entries are never read
  always_ff @(posedge xclk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spi_flash_seq.sv
// SPI-flash read sequencer: CS, command, optional 24-bit address, LEN fill bytes into a receive FIFO.
// Latency: seq_busy rises the cycle after GO; one engine byte per LOAD..CAPTURE loop (engine-paced).
// Backpressure: a full receive FIFO stalls the data phase in LOAD with CS_b held low.
module spi_flash_seq
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CS_HOLD    = 2
) (
  input  logic       xclk,
  input  logic       rst,
  input  logic [2:0] bus_addr,
  input  logic [7:0] bus_din,
  input  logic       bus_wr,
  input  logic       bus_rd,
  output logic [7:0] bus_dout,
  output logic [7:0] eng_din,
  output logic       eng_start,
  input  logic       eng_busy,
  input  logic [7:0] eng_dout,
  output logic       CS_b,
  output logic       seq_busy,
  output logic       irq_b
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

  seq_state_e    state_q, state_d;
  seq_phase_e    phase_q, phase_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [23:0]   addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic          addr_en_q, addr_en_d;
  logic          irq_en_q, irq_en_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
  logic [8:0]    data_left_q, data_left_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          cs_b_q, cs_b_d;
  logic          eng_start_q, eng_start_d;
  logic [7:0]    eng_din_q, eng_din_d;
  logic          seq_busy_q, seq_busy_d;

  logic          ctrl_wr, go_req, abort_req, stat_rd, desel_go;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dat;
  logic [CW-1:0] fifo_count;

  assign ctrl_wr   = bus_wr && (bus_addr == REG_CTRL);
  assign go_req    = ctrl_wr && bus_din[CTRL_GO] && (state_q == ST_IDLE);
  assign abort_req = ctrl_wr && bus_din[CTRL_ABORT];
  assign stat_rd   = bus_rd && (bus_addr == REG_STAT);
  assign fifo_pop  = bus_rd && (bus_addr == REG_DATA);

  assign CS_b      = cs_b_q;
  assign eng_start = eng_start_q;
  assign eng_din   = eng_din_q;
  assign seq_busy  = seq_busy_q;
  assign irq_b     = !(irq_en_q && (done_q || (fifo_count >= CW'(FIFO_DEPTH / 2))));

  seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .xclk     (xclk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (eng_dout),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Read mux; address 6 shows the FIFO head that the same strobe pops
  always_comb begin
    bus_dout = FILL_BYTE;
    case (bus_addr)
      REG_STAT: bus_dout = {4'b0000, fifo_full, fifo_empty, done_q, seq_busy_q};
      REG_DATA: bus_dout = fifo_dat;
      REG_CNT:  bus_dout = 8'(fifo_count);
      default:  bus_dout = FILL_BYTE;
    endcase
  end

  // Register file and sequencer next-state
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    addr_en_d   = addr_en_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    abort_d     = abort_q;
    data_left_d = data_left_q;
    hold_cnt_d  = hold_cnt_q;
    cs_b_d      = cs_b_q;
    eng_start_d = 1'b0;
    eng_din_d   = eng_din_q;
    seq_busy_d  = seq_busy_q;
    fifo_push   = 1'b0;
    desel_go    = 1'b0;

    // Transaction setup is frozen while a transaction runs
    if (bus_wr && !seq_busy_q) begin
      case (bus_addr)
        REG_CMD:   cmd_d          = bus_din;
        REG_ADDR0: addr_d[7:0]    = bus_din;
        REG_ADDR1: addr_d[15:8]   = bus_din;
        REG_ADDR2: addr_d[23:16]  = bus_din;
        REG_LEN:   len_d          = bus_din;
        default:   ;
      endcase
    end
    // IRQ enable may change any time; ADDR_EN only between transactions
    if (ctrl_wr) begin
      irq_en_d = bus_din[CTRL_IRQ_EN];
      if (!seq_busy_q) begin
        addr_en_d = bus_din[CTRL_ADDR_EN];
      end
    end
    if (stat_rd) begin
      done_d = 1'b0;
    end
    // An abort while a byte is on the wire waits for that byte to finish
    if (abort_req && (state_q == ST_SEND || state_q == ST_WAIT_HI || state_q == ST_WAIT_LO)) begin
      abort_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (go_req) begin
          state_d     = ST_CS_SETUP;
          cs_b_d      = 1'b0;
          seq_busy_d  = 1'b1;
          done_d      = 1'b0;
          abort_d     = 1'b0;
          phase_d     = PH_CMD;
          data_left_d = {1'b0, len_q};
        end
      end
      ST_CS_SETUP: begin
        if (abort_req) desel_go = 1'b1;
        else           state_d  = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort_req) begin
          desel_go = 1'b1;
        end else begin
          case (phase_q)
            PH_CMD:   begin eng_din_d = cmd_q;         eng_start_d = 1'b1; end
            PH_ADDR2: begin eng_din_d = addr_q[23:16]; eng_start_d = 1'b1; end
            PH_ADDR1: begin eng_din_d = addr_q[15:8];  eng_start_d = 1'b1; end
            PH_ADDR0: begin eng_din_d = addr_q[7:0];   eng_start_d = 1'b1; end
            default: begin
              if (data_left_q == 9'd0) begin
                desel_go = 1'b1;
              end else if (!fifo_full) begin
                eng_din_d   = FILL_BYTE;
                eng_start_d = 1'b1;
              end
            end
          endcase
          if (eng_start_d) state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (eng_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!eng_busy) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Engine has settled eng_dout by now; only data bytes are kept
        if (phase_q == PH_DATA) begin
          fifo_push   = 1'b1;
          data_left_d = data_left_q - 9'd1;
        end
        phase_d = next_phase(phase_q, addr_en_q);
        if (abort_q || abort_req) desel_go = 1'b1;
        else                      state_d  = ST_LOAD;
      end
      ST_DESEL: begin
        if (hold_cnt_q == HW'(CS_HOLD - 1)) begin
          state_d    = ST_IDLE;
          seq_busy_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Common exit into deselect; completion wins over a same-cycle STATUS read
    if (desel_go) begin
      state_d    = ST_DESEL;
      cs_b_d     = 1'b1;
      done_d     = 1'b1;
      abort_d    = 1'b0;
      hold_cnt_d = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge xclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_CMD;
      cmd_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      addr_en_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      data_left_q <= '0;
      hold_cnt_q  <= '0;
      cs_b_q      <= 1'b1;
      eng_start_q <= 1'b0;
      eng_din_q   <= '0;
      seq_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      addr_en_q   <= addr_en_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      data_left_q <= data_left_d;
      hold_cnt_q  <= hold_cnt_d;
      cs_b_q      <= cs_b_d;
      eng_start_q <= eng_start_d;
      eng_din_q   <= eng_din_d;
      seq_busy_q  <= seq_busy_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_seq.sv
// Bench for spi_flash_seq with a behavioural byte engine (1-cycle busy delay, 16-cycle transfer).
// Latency: engine returns 8'hA0+i for the i-th byte since CS_b fell.
// Backpressure: the bench stops popping to fill the FIFO and exercise the stall.
module tb_spi_flash_seq;
  import spi_seq_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int CS_HOLD    = 2;

  logic       xclk = 1'b0;
  logic       rst;
  logic [2:0] bus_addr;
  logic [7:0] bus_din;
  logic       bus_wr, bus_rd;
  logic [7:0] bus_dout, eng_din, eng_dout;
  logic       eng_start, eng_busy, CS_b, seq_busy, irq_b;

  always #5 xclk = ~xclk;

  spi_flash_seq #(.FIFO_DEPTH(FIFO_DEPTH), .CS_HOLD(CS_HOLD)) dut (
    .xclk(xclk), .rst(rst), .bus_addr(bus_addr), .bus_din(bus_din),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_dout(bus_dout),
    .eng_din(eng_din), .eng_start(eng_start), .eng_busy(eng_busy),
    .eng_dout(eng_dout), .CS_b(CS_b), .seq_busy(seq_busy), .irq_b(irq_b)
  );

  // Behavioural SPI byte engine
  logic       pend;
  int         eng_cnt;
  logic [7:0] eng_idx;
  always @(posedge xclk) begin
    if (rst) begin
      eng_busy <= 1'b0; pend <= 1'b0; eng_cnt <= 0; eng_idx <= 8'd0; eng_dout <= 8'd0;
    end else begin
      if (CS_b) eng_idx <= 8'd0;
      if (pend) begin
        pend <= 1'b0; eng_busy <= 1'b1; eng_cnt <= 16;
      end else if (eng_busy) begin
        if (eng_cnt == 1) begin
          eng_busy <= 1'b0; eng_dout <= 8'hA0 + eng_idx; eng_idx <= eng_idx + 8'd1;
        end
        eng_cnt <= eng_cnt - 1;
      end else if (eng_start) begin
        pend <= 1'b1;
      end
    end
  end

  // Pin monitor, sampled on the falling edge
  int         n_start = 0, cs_bad = 0, dbl_start = 0, cs_rise = 0;
  int         hi_run = 0, last_hi_run = 0, desel_cyc = 0;
  logic       prev_start = 1'b0, prev_cs = 1'b1;
  logic [7:0] sent_q[$];
  always @(negedge xclk) begin
    if (eng_start) begin
      n_start++;
      sent_q.push_back(eng_din);
      if (CS_b) cs_bad++;
      if (prev_start) dbl_start++;
    end
    prev_start = eng_start;
    if (CS_b) hi_run++;
    else begin
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
    end
    if (CS_b && !prev_cs) cs_rise++;
    prev_cs = CS_b;
    if (CS_b && seq_busy) desel_cyc++;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus_addr = a; bus_din = d; bus_wr = 1'b1;
    @(negedge xclk);
    bus_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    bus_addr = a; bus_rd = 1'b1;
    #1 d = bus_dout;
    @(negedge xclk);
    bus_rd = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (seq_busy && k < budget) begin @(negedge xclk); #1; k++; end
    check("wait_idle", seq_busy, 0);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k = 0;
    while (n_start < target && k < budget) begin @(negedge xclk); #1; k++; end
    check("wait_starts", n_start >= target, 1);
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [7:0] exp;
  } rvec_t;

  rvec_t      rv[8];
  logic [7:0] exp1[8];
  logic [7:0] d;
  int         base, des0, rise0, popped, guard, k;

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = 3'd0; bus_din = 8'd0;
    repeat (3) @(negedge xclk);
    rst = 1'b0;
    @(negedge xclk); #1;

    // Reset state of pins
    check("rst_cs_b", CS_b, 1);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_din", eng_din, 0);
    check("rst_seq_busy", seq_busy, 0);
    check("rst_irq_b", irq_b, 1);

    // Reset state of the register map
    rv[0] = '{REG_CMD,   8'hFF};
    rv[1] = '{REG_ADDR0, 8'hFF};
    rv[2] = '{REG_ADDR1, 8'hFF};
    rv[3] = '{REG_ADDR2, 8'hFF};
    rv[4] = '{REG_LEN,   8'hFF};
    rv[5] = '{REG_STAT,  8'h04};
    rv[6] = '{REG_DATA,  8'hFF};
    rv[7] = '{REG_CNT,   8'h00};
    for (int i = 0; i < 8; i++) begin
      rd(rv[i].addr, d);
      check($sformatf("rst_reg%0d", rv[i].addr), d, rv[i].exp);
    end

    // T1: read with address, LEN=4; setup writes and GO while busy must be ignored
    exp1 = '{8'h03, 8'h01, 8'h23, 8'h45, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    base = n_start; des0 = desel_cyc; rise0 = cs_rise;
    wr(REG_CMD, 8'h03); wr(REG_ADDR0, 8'h45); wr(REG_ADDR1, 8'h23); wr(REG_ADDR2, 8'h01);
    wr(REG_LEN, 8'h04); wr(REG_CTRL, 8'h05);
    #1;
    check("t1_busy_after_go", seq_busy, 1);
    check("t1_cs_low_setup", CS_b, 0);
    wait_starts(base + 2, 200);
    wr(REG_CMD, 8'h77); wr(REG_LEN, 8'h09); wr(REG_CTRL, 8'h05);
    wait_idle(600);
    check("t1_starts", n_start - base, 8);
    for (int i = 0; i < 8; i++) check($sformatf("t1_byte%0d", i), sent_q[base + i], exp1[i]);
    check("t1_cs_single_rise", cs_rise - rise0, 1);
    check("t1_desel_cycles", desel_cyc - des0, CS_HOLD);
    rd(REG_CNT, d);  check("t1_count", d, 4);
    rd(REG_STAT, d); check("t1_status_done", d, 8'h02);
    rd(REG_STAT, d); check("t1_status_cleared", d, 8'h00);
    check("t1_irq_disabled", irq_b, 1);
    for (int i = 0; i < 4; i++) begin
      rd(REG_DATA, d); check($sformatf("t1_pop%0d", i), d, 8'hA4 + i);
    end
    rd(REG_DATA, d); check("t1_pop_empty", d, 8'hFF);
    rd(REG_CNT, d);  check("t1_count_empty", d, 0);

    // T1b: retained CMD/LEN, no address, IRQ enabled
    base = n_start;
    wr(REG_CTRL, 8'h09);
    wait_idle(400);
    check("t1b_starts", n_start - base, 5);
    check("t1b_cmd_kept", sent_q[base], 8'h03);
    check("t1b_fill", sent_q[base + 1], 8'hFF);
    check("t1b_irq_done", irq_b, 0);
    rd(REG_STAT, d); check("t1b_status", d, 8'h02);
    #1 check("t1b_irq_half_full", irq_b, 0);
    rd(REG_DATA, d); check("t1b_pop0", d, 8'hA1);
    #1 check("t1b_irq_below_half", irq_b, 1);
    for (int i = 1; i < 4; i++) begin
      rd(REG_DATA, d); check($sformatf("t1b_pop%0d", i), d, 8'hA1 + i);
    end
    wr(REG_CTRL, 8'h00);

    // T2: LEN=12 without popping stalls at FIFO full
    wr(REG_CMD, 8'h0B); wr(REG_LEN, 8'h0C);
    base = n_start;
    wr(REG_CTRL, 8'h01);
    wait_starts(base + 9, 600);
    repeat (60) @(negedge xclk);
    #1;
    check("t2_starts_stalled", n_start - base, 9);
    check("t2_cs_low_stall", CS_b, 0);
    check("t2_busy_stall", seq_busy, 1);
    rd(REG_STAT, d); check("t2_status_full", d, 8'h09);
    rd(REG_CNT, d);  check("t2_count_full", d, 8);
    rd(REG_DATA, d); check("t2_pop0", d, 8'hA1);
    k = 0;
    while (!eng_start && k < 2) begin @(negedge xclk); #1; k++; end
    check("t2_restart", eng_start, 1);
    popped = 1; guard = 0;
    while (popped < 12 && guard < 3000) begin
      rd(REG_CNT, d);
      if (d != 8'd0) begin
        rd(REG_DATA, d);
        check($sformatf("t2_pop%0d", popped), d, 8'hA1 + popped);
        popped++;
      end
      guard++;
    end
    check("t2_popped_total", popped, 12);
    wait_idle(400);
    check("t2_starts_total", n_start - base, 13);
    rd(REG_STAT, d); check("t2_status_end", d, 8'h06);

    // T3: command-only transaction, then back-to-back GO
    base = n_start; des0 = desel_cyc;
    wr(REG_CMD, 8'h06); wr(REG_LEN, 8'h00);
    wr(REG_CTRL, 8'h01);
    wait_idle(200);
    check("t3_starts", n_start - base, 1);
    check("t3_byte", sent_q[base], 8'h06);
    check("t3_desel_cycles", desel_cyc - des0, CS_HOLD);
    wr(REG_CTRL, 8'h01);
    wait_idle(200);
    check("t3_starts_2", n_start - base, 2);
    check("t3_cs_hold", last_hi_run >= CS_HOLD, 1);
    rd(REG_STAT, d); check("t3_status", d, 8'h06);

    // T4: ABORT during the 2nd data byte of LEN=8
    wr(REG_CMD, 8'h03); wr(REG_LEN, 8'h08);
    base = n_start;
    wr(REG_CTRL, 8'h01);
    wait_starts(base + 3, 300);
    repeat (5) @(negedge xclk);
    wr(REG_CTRL, 8'h02);
    wait_idle(200);
    check("t4_starts", n_start - base, 3);
    rd(REG_CNT, d);  check("t4_count", d, 2);
    rd(REG_STAT, d); check("t4_status", d, 8'h02);
    rd(REG_DATA, d); check("t4_pop0", d, 8'hA1);
    rd(REG_DATA, d); check("t4_pop1", d, 8'hA2);

    // T6: reset while the sequencer waits for busy low
    base = n_start;
    wr(REG_CTRL, 8'h09);
    wait_starts(base + 3, 300);
    k = 0;
    while (!eng_busy && k < 50) begin @(negedge xclk); #1; k++; end
    check("t6_engine_busy", eng_busy, 1);
    repeat (2) @(negedge xclk);
    bus_addr = REG_CNT;
    #1 check("t6_count_before", bus_dout, 1);
    rst = 1'b1;
    @(negedge xclk); #1;
    check("t6_cs_b", CS_b, 1);
    check("t6_seq_busy", seq_busy, 0);
    check("t6_irq_b", irq_b, 1);
    check("t6_eng_start", eng_start, 0);
    bus_addr = REG_CNT;
    #1 check("t6_count", bus_dout, 0);
    rst = 1'b0;
    repeat (2) @(negedge xclk);
    rd(REG_STAT, d); check("t6_status", d, 8'h04);

    check("cs_low_on_every_start", cs_bad, 0);
    check("start_single_cycle", dbl_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
